// File: rtl/threshold_pkg.sv
// Shared types and helpers for the double-threshold classifier.
package threshold_pkg;

  // Widest pixel the classify() helper compares; callers zero-extend to this.
  localparam int PIX_MAX_W = 32;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } pixel_class_t;

  // Unsigned double-threshold decision. When low > high the WEAK band is empty,
  // because any pixel >= low is then also >= high.
  function automatic pixel_class_t classify(input logic [PIX_MAX_W-1:0] pixel,
                                            input logic [PIX_MAX_W-1:0] low,
                                            input logic [PIX_MAX_W-1:0] high);
    if (pixel >= high) return CLS_STRONG;
    if (pixel >= low)  return CLS_WEAK;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer. The head entry drives the outputs directly, so
// data appears one cycle after acceptance; o_ready is a flop, never a function
// of i_ready.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, occupancy and the registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the entries are reset too, because the head drives o_data and must read 0 out of reset.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      case (count_q)
        2'd0: if (push) head_q <= i_data;
        2'd1: begin
          if (push && pop) head_q <= i_data;
          else if (push)   tail_q <= i_data;
        end
        2'd2: if (pop) head_q <= tail_q;
        default: ;
      endcase
      count_q <= count_d;
      o_valid <= (count_d != 2'd0);
      o_ready <= (count_d != 2'd2);
    end
  end

  assign o_data = head_q;

endmodule

// File: rtl/dual_threshold_stream.sv
// Streaming STRONG/WEAK/NONE classifier with frame-synchronous threshold
// updates and per-frame class statistics.
// Optional feature: define HYST_ROW_EN to promote WEAK pixels that directly
// follow a STRONG pixel on the same line (1-D hysteresis, chaining rightward).
module dual_threshold_stream
  import threshold_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 20,
  parameter int DEF_HIGH   = 100,
  parameter int DEF_LOW    = 40,
  parameter int HIGH_VALUE = 255,
  parameter int WEAK_VALUE = 128,
  parameter int LOW_VALUE  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_pixel,
  input  logic              i_sof,
  input  logic              i_eol,
  input  logic              i_eof,
  input  logic              i_cfg_we,
  input  logic [DATA_W-1:0] i_cfg_high,
  input  logic [DATA_W-1:0] i_cfg_low,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_pixel,
  output logic [1:0]        o_class,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic [CNT_W-1:0]  o_strong_cnt,
  output logic [CNT_W-1:0]  o_weak_cnt,
  output logic              o_stats_valid
);

  localparam int PAY_W = DATA_W + 5;
  localparam logic [DATA_W-1:0] HIGH_PIX = DATA_W'(HIGH_VALUE);
  localparam logic [DATA_W-1:0] WEAK_PIX = DATA_W'(WEAK_VALUE);
  localparam logic [DATA_W-1:0] LOW_PIX  = DATA_W'(LOW_VALUE);

  logic              accept;
  logic [DATA_W-1:0] act_high, act_low;
  logic [DATA_W-1:0] sh_high, sh_low;
  logic [DATA_W-1:0] use_high, use_low;
  pixel_class_t      raw_cls, fin_cls;
  logic [DATA_W-1:0] map_pix;
  logic [CNT_W-1:0]  strong_cnt, weak_cnt;
  logic [CNT_W-1:0]  strong_base, weak_base;
  logic [CNT_W-1:0]  strong_nxt, weak_nxt;
  logic [PAY_W-1:0]  in_data, out_data;

  assign accept = i_valid & o_ready;

  // Thresholds seen by this pixel: a frame-start pixel already uses the shadow
  // values, and a write landing in that same cycle takes priority.
  always_comb begin
    use_high = act_high;
    use_low  = act_low;
    if (i_sof) begin
      use_high = i_cfg_we ? i_cfg_high : sh_high;
      use_low  = i_cfg_we ? i_cfg_low  : sh_low;
    end
  end

  assign raw_cls = classify(32'(i_pixel), 32'(use_low), 32'(use_high));

`ifdef HYST_ROW_EN
  logic line_start;
  logic prev_strong;

  // Promote WEAK after STRONG within a line; the chain restarts at frame and line starts.
  always_comb begin
    fin_cls = raw_cls;
    if (raw_cls == CLS_WEAK && prev_strong && !line_start && !i_sof) fin_cls = CLS_STRONG;
  end

  // Track line boundaries and the class of the previous pixel for the chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_start  <= 1'b1;
      prev_strong <= 1'b0;
    end else if (accept) begin
      line_start  <= i_eol;
      prev_strong <= (fin_cls == CLS_STRONG);
    end
  end
`else
  assign fin_cls = raw_cls;
`endif

  // Output pixel value for the final class.
  always_comb begin
    case (fin_cls)
      CLS_STRONG: map_pix = HIGH_PIX;
      CLS_WEAK:   map_pix = WEAK_PIX;
      default:    map_pix = LOW_PIX;
    endcase
  end

  // Saturating next counts; a frame start discards any unfinished totals.
  always_comb begin
    strong_base = i_sof ? '0 : strong_cnt;
    weak_base   = i_sof ? '0 : weak_cnt;
    strong_nxt  = strong_base;
    weak_nxt    = weak_base;
    if (fin_cls == CLS_STRONG && strong_base != '1) strong_nxt = strong_base + CNT_W'(1);
    if (fin_cls == CLS_WEAK   && weak_base   != '1) weak_nxt   = weak_base   + CNT_W'(1);
  end

  // Shadow threshold writes and frame-start copy into the active set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_high <= DATA_W'(DEF_HIGH);
      act_low  <= DATA_W'(DEF_LOW);
      sh_high  <= DATA_W'(DEF_HIGH);
      sh_low   <= DATA_W'(DEF_LOW);
    end else begin
      if (i_cfg_we) begin
        sh_high <= i_cfg_high;
        sh_low  <= i_cfg_low;
      end
      if (accept && i_sof) begin
        act_high <= use_high;
        act_low  <= use_low;
      end
    end
  end

  // Running counts, published and cleared on the end-of-frame pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strong_cnt    <= '0;
      weak_cnt      <= '0;
      o_strong_cnt  <= '0;
      o_weak_cnt    <= '0;
      o_stats_valid <= 1'b0;
    end else begin
      o_stats_valid <= 1'b0;
      if (accept) begin
        if (i_eof) begin
          o_strong_cnt  <= strong_nxt;
          o_weak_cnt    <= weak_nxt;
          o_stats_valid <= 1'b1;
          strong_cnt    <= '0;
          weak_cnt      <= '0;
        end else begin
          strong_cnt <= strong_nxt;
          weak_cnt   <= weak_nxt;
        end
      end
    end
  end

  assign in_data = {map_pix, fin_cls, i_sof, i_eol, i_eof};

  stream_skid_buffer #(.WIDTH(PAY_W)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (in_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (out_data)
  );

  assign {o_pixel, o_class, o_sof, o_eol, o_eof} = out_data;

endmodule

// File: tb/tb_dual_threshold_stream.sv
// Scoreboard bench for dual_threshold_stream: a reference model pushes expected
// outputs and frame statistics on each accepted pixel; monitors pop and compare.
module tb_dual_threshold_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 20;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DATA_W-1:0] i_pixel = '0;
  logic              i_sof = 1'b0, i_eol = 1'b0, i_eof = 1'b0;
  logic              i_cfg_we = 1'b0;
  logic [DATA_W-1:0] i_cfg_high = '0, i_cfg_low = '0;
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic [DATA_W-1:0] o_pixel;
  logic [1:0]        o_class;
  logic              o_sof, o_eol, o_eof;
  logic [CNT_W-1:0]  o_strong_cnt, o_weak_cnt;
  logic              o_stats_valid;

  dual_threshold_stream dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_pixel(i_pixel), .i_sof(i_sof), .i_eol(i_eol), .i_eof(i_eof),
    .i_cfg_we(i_cfg_we), .i_cfg_high(i_cfg_high), .i_cfg_low(i_cfg_low),
    .o_valid(o_valid), .i_ready(i_ready), .o_pixel(o_pixel), .o_class(o_class),
    .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_strong_cnt(o_strong_cnt), .o_weak_cnt(o_weak_cnt), .o_stats_valid(o_stats_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] px;
    logic [1:0] cls;
    logic       sof, eol, eof;
  } exp_t;

  exp_t        sb_q[$];
  logic [39:0] st_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic ready_dropped = 1'b0;

  // Reference model state.
  int m_act_hi, m_act_lo, m_sh_hi, m_sh_lo, m_strong, m_weak;
  bit m_line_start, m_prev_strong;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act_hi = 100; m_act_lo = 40; m_sh_hi = 100; m_sh_lo = 40;
    m_strong = 0; m_weak = 0; m_line_start = 1; m_prev_strong = 0;
  endtask

  task automatic model_accept(input int px, input bit sof, eol, eof,
                              input bit we, input int hi, lo);
    int h, l, cls;
    exp_t e;
    h = m_act_hi; l = m_act_lo;
    if (sof) begin
      h = we ? hi : m_sh_hi;
      l = we ? lo : m_sh_lo;
      m_act_hi = h; m_act_lo = l;
    end
    if (we) begin m_sh_hi = hi; m_sh_lo = lo; end
    cls = (px >= h) ? 2 : (px >= l) ? 1 : 0;
`ifdef HYST_ROW_EN
    if (cls == 1 && m_prev_strong && !m_line_start && !sof) cls = 2;
    m_prev_strong = (cls == 2);
    m_line_start = eol;
`endif
    e.px  = (cls == 2) ? 8'd255 : (cls == 1) ? 8'd128 : 8'd0;
    e.cls = 2'(cls);
    e.sof = sof; e.eol = eol; e.eof = eof;
    sb_q.push_back(e);
    if (sof) begin m_strong = 0; m_weak = 0; end
    if (cls == 2) m_strong++;
    if (cls == 1) m_weak++;
    if (eof) begin
      st_q.push_back({20'(m_strong), 20'(m_weak)});
      m_strong = 0; m_weak = 0;
    end
  endtask

  // Drive one pixel, hold until accepted, update the model on acceptance.
  task automatic send(input int px, input bit sof, input bit eol, input bit eof,
                      input bit we = 0, input int hi = 0, input int lo = 0);
    bit took = 0;
    i_valid = 1'b1; i_pixel = 8'(px); i_sof = sof; i_eol = eol; i_eof = eof;
    i_cfg_we = we; i_cfg_high = 8'(hi); i_cfg_low = 8'(lo);
    for (int k = 0; k < 100 && !took; k++) begin
      @(negedge i_clk);
      took = o_ready;
      @(posedge i_clk);
      #1;
    end
    if (took) model_accept(px, sof, eol, eof, we, hi, lo);
    else check("send_timeout", 32'(took), 32'd1);
    i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0; i_eof = 1'b0; i_cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input int hi, input int lo);
    i_cfg_we = 1'b1; i_cfg_high = 8'(hi); i_cfg_low = 8'(lo);
    @(posedge i_clk);
    #1;
    i_cfg_we = 1'b0;
    m_sh_hi = hi; m_sh_lo = lo;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb_q.size() != 0; k++) @(posedge i_clk);
    repeat (2) @(posedge i_clk);
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  // Output and statistics monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (!o_ready) ready_dropped = 1'b1;
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_pixel", 32'(o_pixel), 32'(e.px));
          check("out_class", 32'(o_class), 32'(e.cls));
          check("out_side", {29'd0, o_sof, o_eol, o_eof}, {29'd0, e.sof, e.eol, e.eof});
        end
      end
      if (o_stats_valid) begin
        if (st_q.size() == 0) check("stats_underflow", st_q.size(), 1);
        else begin
          logic [39:0] s;
          s = st_q.pop_front();
          check("stats_strong", 32'(o_strong_cnt), 32'(s[39:20]));
          check("stats_weak", 32'(o_weak_cnt), 32'(s[19:0]));
        end
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ready", 32'(o_ready), 1);
    check("rst_pixel", 32'(o_pixel), 0);
    check("rst_class", 32'(o_class), 0);
    check("rst_cnt", 32'(o_strong_cnt) + 32'(o_weak_cnt) + 32'(o_stats_valid), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Defaults 100/40: WEAK, STRONG, WEAK, NONE.
    send(99, 1, 0, 0);
    check("latency_1", 32'(o_valid), 1);
    send(100, 0, 0, 0);
    send(40, 0, 0, 0);
    send(39, 0, 1, 1);
    drain();
    check("frameA_strong", 32'(o_strong_cnt), 1);
    check("frameA_weak", 32'(o_weak_cnt), 2);

    // Mid-frame write is deferred to the next frame start.
    send(60, 1, 0, 0);
    cfg_write(50, 10);
    send(60, 0, 0, 0);
    send(30, 0, 0, 1);
    send(60, 1, 0, 0);
    send(20, 0, 0, 0);
    send(5, 0, 0, 1);
    // Write coinciding with frame start: new values apply to that pixel.
    send(160, 1, 0, 0, 1, 200, 150);
    send(210, 0, 0, 1);
    // low > high: WEAK never occurs.
    cfg_write(50, 80);
    send(60, 1, 0, 0);
    send(45, 0, 0, 0);
    send(79, 0, 0, 1);
    cfg_write(100, 40);
    drain();

    // Backpressure burst of 10 pixels.
    ready_dropped = 1'b0;
    fork
      for (int i = 0; i < 10; i++) send(30 + i * 15, i == 0, 0, i == 9);
      begin
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    check("burst_ready_drop", 32'(ready_dropped), 1);

    // 3 STRONG + 2 WEAK, then a one-pixel frame.
    send(150, 1, 0, 0);
    send(120, 0, 0, 0);
    send(45, 0, 0, 0);
    send(200, 0, 0, 0);
    send(60, 0, 0, 1);
    drain();
    check("frameG_strong", 32'(o_strong_cnt), 3);
    check("frameG_weak", 32'(o_weak_cnt), 2);
    send(10, 1, 0, 1);
    drain();
    check("frameH_strong", 32'(o_strong_cnt), 0);
    check("frameH_weak", 32'(o_weak_cnt), 0);

    // Frame start without a preceding end discards the partial totals.
    send(200, 1, 0, 0);
    send(200, 0, 0, 0);
    send(50, 1, 0, 1);
    drain();
    check("frameJ_strong", 32'(o_strong_cnt), 0);
    check("frameJ_weak", 32'(o_weak_cnt), 1);

    // Line with end-of-line on the 3rd pixel.
    send(200, 1, 0, 0);
    send(50, 0, 0, 0);
    send(50, 0, 1, 0);
    send(10, 0, 0, 0);
    send(50, 0, 0, 1);
    drain();
`ifdef HYST_ROW_EN
    check("hyst_strong", 32'(o_strong_cnt), 3);
    check("hyst_weak", 32'(o_weak_cnt), 1);
`else
    check("nohyst_strong", 32'(o_strong_cnt), 1);
    check("nohyst_weak", 32'(o_weak_cnt), 3);
`endif

    // Reset mid-burst with the buffer full.
    i_ready = 1'b0;
    send(30, 1, 0, 0);
    send(31, 0, 0, 0);
    i_valid = 1'b1; i_pixel = 8'd32;
    @(negedge i_clk);
    check("full_ready", 32'(o_ready), 0);
    #2 i_rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(o_valid), 0);
    check("mrst_pixel", 32'(o_pixel), 0);
    check("mrst_class", 32'(o_class), 0);
    check("mrst_side", {29'd0, o_sof, o_eol, o_eof}, 0);
    check("mrst_cnt", 32'(o_strong_cnt) + 32'(o_weak_cnt) + 32'(o_stats_valid), 0);
    i_valid = 1'b0;
    sb_q.delete();
    st_q.delete();
    model_reset();
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("mrst_ready", 32'(o_ready), 1);
    @(posedge i_clk);
    #1;
    send(99, 1, 0, 1);
    drain();
    check("post_rst_weak", 32'(o_weak_cnt), 1);
    check("stats_left", st_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
